stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Centisecond stopwatch datapath and control. It consumes the one-cycle centisecond enable pulse produced by the upstream clock-modulation stage. It keeps a BCD count in MM:SS.cc format and implements start/stop, lap-freeze and clear. It drives the six BCD digits to the downstream seven-segment display driver.

## Interface
- MINUTE_MAX, default 59, highest minute value before wrap; legal range 1..99.
- clk  input  1  system clock; every register is clocked on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- tick  input  1  centisecond enable; a one-cycle pulse synchronous to clk, at most one per cycle.
- start_stop  input  1  debounced one-cycle command pulse.
- lap  input  1  debounced one-cycle command pulse.
- clear  input  1  debounced one-cycle command pulse.
- min_t, min_o  output  4 each  minute tens and ones digits (BCD).
- sec_t, sec_o  output  4 each  second tens and ones digits (BCD).
- cs_t, cs_o  output  4 each  centisecond tens and ones digits (BCD).
- running  output  1  high in RUN and LAP.
- lap_hold  output  1  high in LAP.
- overflow  output  1  sticky flag; set on wrap past MINUTE_MAX:59.99.

## Operation
- Counter: six registered BCD digits.
  - cs_o rolls 9→0 and carries into cs_t.
  - cs_t rolls 9→0 and carries into sec_o.
  - sec_o rolls 9→0 and carries into sec_t.
  - sec_t rolls 5→0 and carries into the minutes.
  - The minutes roll MINUTE_MAX→00.
  - A digit never holds a value above 9 (sec_t never above 5).
- Increment rule: the counter increments by 0.01 s on a rising edge where tick=1 and the current registered state is RUN or LAP.
- State machine, states IDLE, RUN, PAUSE, LAP:
  - IDLE: start_stop → RUN. lap and clear are ignored.
  - RUN: start_stop → PAUSE. lap → LAP and loads the snapshot register with the current count. clear is ignored.
  - LAP: the counter keeps counting while the display shows the snapshot.
    - lap → RUN; the display returns to live.
    - lap again from RUN takes a fresh snapshot.
    - start_stop → PAUSE; the display shows the live (stopped) count.
    - clear is ignored.
  - PAUSE: start_stop → RUN. clear → IDLE, which zeroes the counter and snapshot and clears overflow. lap is ignored.
- Simultaneous commands: start_stop has priority over lap, and lap has priority over clear. Lower-priority commands in the same cycle are discarded.
- Simultaneous tick and command: the tick is evaluated against the current state.
  - RUN + start_stop + tick: the increment happens, then the state becomes PAUSE.
  - IDLE/PAUSE + start_stop + tick: no increment.
  - RUN + lap + tick: the snapshot takes the pre-increment value and the counter increments.
- Wrap: at MINUTE_MAX:59.99 with a counting tick, the count goes to 00:00.00 and overflow is set. overflow stays set until clear (PAUSE→IDLE) or reset.
- A command input held high for N cycles is treated as N commands.
- Display outputs are a registered-source mux: snapshot when in LAP, counter otherwise.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - All digits, snapshot and outputs = 0.
  - running = lap_hold = overflow = 0.
- Counter latency: the digit outputs show the new value in the cycle after the edge on which tick was sampled (1 clk).
- Command latency: running and lap_hold change 1 clk after the command edge. The displayed snapshot is valid in that same cycle.
- Carry chain: the full ripple 59:59.99→00:00.00 completes in a single edge. No intermediate values are visible.
- Reset asserted mid-count or in LAP returns to IDLE with zero display. It needs no tick and no clock edge.
- No throughput limit: back-to-back ticks on consecutive cycles are each counted.

## Test plan
- Reset, then start_stop, then 123 ticks → display 00:01.23, running=1.
- Preset count to 00:59.99 in RUN, then 1 tick → 01:00.00 in a single cycle, no intermediate value.
- With MINUTE_MAX=59, at 59:59.99, 1 tick → 00:00.00 and overflow=1. Then start_stop, then clear → overflow=0, all digits 0, state IDLE.
- RUN at 00:02.50, lap → display frozen at 00:02.50 and lap_hold=1 over 40 further ticks. Then lap → display 00:02.90.
- RUN at 00:00.07, start_stop and tick in the same cycle → PAUSE with display 00:00.08. Further ticks → no change. clear → 00:00.00.
- RUN at 00:03.00, assert reset asynchronously between clock edges → all outputs 0 immediately. start_stop+lap+clear together in IDLE → RUN only, lap_hold=0.

Source files
------------

// File: rtl/stopwatch_core.sv
// stopwatch_core: centisecond stopwatch with a BCD MM:SS.cc counter,
// start/stop, lap-freeze and clear. The counter advances on the upstream
// centisecond enable while running. A snapshot register holds the lap
// value that is shown while the lap is frozen.

module stopwatch_core #(
  parameter int MINUTE_MAX = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] cs_t,
  output logic [3:0] cs_o,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  // The minute limit is split into BCD tens and ones for the wrap compare.
  localparam logic [3:0] MAX_T = 4'(MINUTE_MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MINUTE_MAX % 10);

  state_t state;

  logic [3:0] cnt_mt, cnt_mo, cnt_st, cnt_so, cnt_ct, cnt_co;
  logic [3:0] snap_mt, snap_mo, snap_st, snap_so, snap_ct, snap_co;
  logic [3:0] nxt_mt, nxt_mo, nxt_st, nxt_so, nxt_ct, nxt_co;

  logic cmd_ss, cmd_lap, cmd_clr;
  logic count_en;
  logic carry_co, carry_ct, carry_so, carry_st, wrap;

  // Resolve simultaneous commands: start_stop beats lap, lap beats clear.
  always_comb begin
    cmd_ss  = start_stop;
    cmd_lap = lap & ~start_stop;
    cmd_clr = clear & ~start_stop & ~lap;
  end

  // A tick counts only against the current registered state.
  always_comb begin
    count_en = tick & ((state == RUN) | (state == LAP));
  end

  // Carry chain across all six digits so a full ripple lands in one edge.
  always_comb begin
    carry_co = (cnt_co == 4'd9);
    carry_ct = carry_co & (cnt_ct == 4'd9);
    carry_so = carry_ct & (cnt_so == 4'd9);
    carry_st = carry_so & (cnt_st == 4'd5);
    wrap     = carry_st & (cnt_mt == MAX_T) & (cnt_mo == MAX_O);
  end

  // Next-count value, one centisecond on from the current count.
  always_comb begin
    nxt_co = carry_co ? 4'd0 : cnt_co + 4'd1;

    nxt_ct = cnt_ct;
    if (carry_co) begin
      nxt_ct = carry_ct ? 4'd0 : cnt_ct + 4'd1;
    end

    nxt_so = cnt_so;
    if (carry_ct) begin
      nxt_so = carry_so ? 4'd0 : cnt_so + 4'd1;
    end

    nxt_st = cnt_st;
    if (carry_so) begin
      nxt_st = carry_st ? 4'd0 : cnt_st + 4'd1;
    end

    nxt_mt = cnt_mt;
    nxt_mo = cnt_mo;
    if (carry_st) begin
      if (wrap) begin
        nxt_mt = 4'd0;
        nxt_mo = 4'd0;
      end else if (cnt_mo == 4'd9) begin
        nxt_mo = 4'd0;
        nxt_mt = cnt_mt + 4'd1;
      end else begin
        nxt_mo = cnt_mo + 4'd1;
      end
    end
  end

  // Control state machine with registered running/lap_hold flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      running  <= 1'b0;
      lap_hold <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ss) begin
            state    <= RUN;
            running  <= 1'b1;
            lap_hold <= 1'b0;
          end
        end
        RUN: begin
          if (cmd_ss) begin
            state    <= PAUSE;
            running  <= 1'b0;
            lap_hold <= 1'b0;
          end else if (cmd_lap) begin
            state    <= LAP;
            running  <= 1'b1;
            lap_hold <= 1'b1;
          end
        end
        LAP: begin
          if (cmd_ss) begin
            state    <= PAUSE;
            running  <= 1'b0;
            lap_hold <= 1'b0;
          end else if (cmd_lap) begin
            state    <= RUN;
            running  <= 1'b1;
            lap_hold <= 1'b0;
          end
        end
        PAUSE: begin
          if (cmd_ss) begin
            state    <= RUN;
            running  <= 1'b1;
            lap_hold <= 1'b0;
          end else if (cmd_clr) begin
            state    <= IDLE;
            running  <= 1'b0;
            lap_hold <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          running  <= 1'b0;
          lap_hold <= 1'b0;
        end
      endcase
    end
  end

  // Live counter: advances on counting ticks, zeroed by clear from PAUSE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_mt <= 4'd0;
      cnt_mo <= 4'd0;
      cnt_st <= 4'd0;
      cnt_so <= 4'd0;
      cnt_ct <= 4'd0;
      cnt_co <= 4'd0;
    end else if ((state == PAUSE) && cmd_clr) begin
      cnt_mt <= 4'd0;
      cnt_mo <= 4'd0;
      cnt_st <= 4'd0;
      cnt_so <= 4'd0;
      cnt_ct <= 4'd0;
      cnt_co <= 4'd0;
    end else if (count_en) begin
      cnt_mt <= nxt_mt;
      cnt_mo <= nxt_mo;
      cnt_st <= nxt_st;
      cnt_so <= nxt_so;
      cnt_ct <= nxt_ct;
      cnt_co <= nxt_co;
    end
  end

  // Snapshot captures the pre-increment count when a lap is taken from RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_mt <= 4'd0;
      snap_mo <= 4'd0;
      snap_st <= 4'd0;
      snap_so <= 4'd0;
      snap_ct <= 4'd0;
      snap_co <= 4'd0;
    end else if ((state == PAUSE) && cmd_clr) begin
      snap_mt <= 4'd0;
      snap_mo <= 4'd0;
      snap_st <= 4'd0;
      snap_so <= 4'd0;
      snap_ct <= 4'd0;
      snap_co <= 4'd0;
    end else if ((state == RUN) && cmd_lap) begin
      snap_mt <= cnt_mt;
      snap_mo <= cnt_mo;
      snap_st <= cnt_st;
      snap_so <= cnt_so;
      snap_ct <= cnt_ct;
      snap_co <= cnt_co;
    end
  end

  // Sticky overflow: set on wrap past the top minute, dropped only by clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if ((state == PAUSE) && cmd_clr) begin
      overflow <= 1'b0;
    end else if (count_en && wrap) begin
      overflow <= 1'b1;
    end
  end

  // Display shows the frozen snapshot in LAP and the live count otherwise.
  always_comb begin
    if (state == LAP) begin
      min_t = snap_mt;
      min_o = snap_mo;
      sec_t = snap_st;
      sec_o = snap_so;
      cs_t  = snap_ct;
      cs_o  = snap_co;
    end else begin
      min_t = cnt_mt;
      min_o = cnt_mo;
      sec_t = cnt_st;
      sec_o = cnt_so;
      cs_t  = cnt_ct;
      cs_o  = cnt_co;
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed-vector bench for stopwatch_core. The minute
// limit is lowered to 10 so the full wrap is reachable in a short run while
// still exercising the minute tens digit.

module tb_stopwatch_core;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] min_t, min_o, sec_t, sec_o, cs_t, cs_o;
  logic       running;
  logic       lap_hold;
  logic       overflow;

  int checkCount;
  int errorCount;

  logic [23:0] disp;
  logic [2:0]  flags;

  stopwatch_core #(.MINUTE_MAX(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .min_t      (min_t),
    .min_o      (min_o),
    .sec_t      (sec_t),
    .sec_o      (sec_o),
    .cs_t       (cs_t),
    .cs_o       (cs_o),
    .running    (running),
    .lap_hold   (lap_hold),
    .overflow   (overflow)
  );

  // Display packed as MMSScc in BCD nibbles; flags as {running,lap_hold,overflow}.
  assign disp  = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};
  assign flags = {running, lap_hold, overflow};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and logs a mismatch.
  task automatic checkOutput(input string tag, input logic [23:0] actual, input logic [23:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, returns just after the rising edge.
  task automatic applyStimulus(input logic s, input logic l, input logic c, input logic t);
    @(negedge clk);
    start_stop = s;
    lap        = l;
    clear      = c;
    tick       = t;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    tick       = 1'b0;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset      = 1'b1;
    tick       = 1'b0;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_disp", disp, 24'h000000);
    checkOutput("reset_flags", {21'd0, flags}, 24'h000000);
    @(negedge clk);
    reset = 1'b0;

    // Start and count 123 centiseconds.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_flags", {21'd0, flags}, 24'h000004);
    runTicks(123);
    checkOutput("count_123", disp, 24'h000123);
    checkOutput("count_123_flags", {21'd0, flags}, 24'h000004);

    // Seconds-to-minutes carry in a single edge.
    runTicks(5876);
    checkOutput("pre_minute", disp, 24'h005999);
    runTicks(1);
    checkOutput("minute_carry", disp, 24'h010000);

    // Run up to the top of the range and wrap.
    runTicks(59999);
    checkOutput("pre_wrap", disp, 24'h105999);
    checkOutput("pre_wrap_flags", {21'd0, flags}, 24'h000004);
    runTicks(1);
    checkOutput("wrap_disp", disp, 24'h000000);
    checkOutput("wrap_flags", {21'd0, flags}, 24'h000005);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("pause_ovf_flags", {21'd0, flags}, 24'h000001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pause_tick", disp, 24'h000000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("clear_disp", disp, 24'h000000);
    checkOutput("clear_flags", {21'd0, flags}, 24'h000000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("idle_ignore_disp", disp, 24'h000000);
    checkOutput("idle_ignore_flags", {21'd0, flags}, 24'h000000);

    // Lap freeze while the counter keeps going.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(250);
    checkOutput("lap_base", disp, 24'h000250);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lap_disp", disp, 24'h000250);
    checkOutput("lap_flags", {21'd0, flags}, 24'h000006);
    runTicks(40);
    checkOutput("lap_frozen", disp, 24'h000250);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lap_release", disp, 24'h000290);
    checkOutput("lap_release_flags", {21'd0, flags}, 24'h000004);

    // Lap with tick: snapshot is pre-increment, counter advances.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("lap_tick_snap", disp, 24'h000290);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lap_tick_live", disp, 24'h000291);

    // start_stop in LAP pauses and shows the live count.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("lap_over_clear", {21'd0, flags}, 24'h000006);
    runTicks(5);
    checkOutput("lap2_frozen", disp, 24'h000291);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lap_to_pause", disp, 24'h000296);
    checkOutput("lap_to_pause_flags", {21'd0, flags}, 24'h000000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("clear2", disp, 24'h000000);

    // start_stop with tick: counts from RUN, not from PAUSE.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(7);
    checkOutput("run_007", disp, 24'h000007);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("stop_tick_disp", disp, 24'h000008);
    checkOutput("stop_tick_flags", {21'd0, flags}, 24'h000000);
    runTicks(5);
    checkOutput("paused_hold", disp, 24'h000008);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("resume_tick_disp", disp, 24'h000008);
    checkOutput("resume_tick_flags", {21'd0, flags}, 24'h000004);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("clear3", disp, 24'h000000);

    // Asynchronous reset between edges while running.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(300);
    checkOutput("run_300", disp, 24'h000300);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_disp", disp, 24'h000000);
    checkOutput("async_reset_flags", {21'd0, flags}, 24'h000000);
    @(negedge clk);
    reset = 1'b0;

    // All three commands together in IDLE: only start_stop acts.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("idle_all_cmds", {21'd0, flags}, 24'h000004);
    checkOutput("idle_all_disp", disp, 24'h000000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
